// File: rtl/huff_bit_decoder.sv
// huff_bit_decoder
//   Serial Huffman decoder. It holds a 16-entry code table of
//   {len, code}, shifts in one encoded bit per accepted handshake, and
//   emits the matching 4-bit symbol on a registered valid/ready port.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   tbl_we/addr/len/code  table write; len == 0 marks an unused entry
//   tbl_clr           invalidate all entries and clear err (beats tbl_we)
//   bit_in/valid/ready    encoded bit stream, MSB of each code first
//   sym_out/valid/ready   decoded symbol output
//   err               sticky: no code matched within MAXLEN bits
//   sym_cnt           wrapping count of delivered symbols
module huff_bit_decoder #(
  parameter int unsigned MAXLEN = 15,
  parameter int unsigned CNTW   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tbl_we,
  input  logic [3:0]        tbl_addr,
  input  logic [3:0]        tbl_len,
  input  logic [MAXLEN-1:0] tbl_code,
  input  logic              tbl_clr,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [3:0]        sym_out,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              err,
  output logic [CNTW-1:0]   sym_cnt
);

  logic [3:0]        len_q  [16];
  logic [MAXLEN-1:0] code_q [16];

  logic [MAXLEN-1:0] acc_q, acc_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        sym_out_q, sym_out_d;
  logic              sym_valid_q, sym_valid_d;
  logic              err_q, err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              accept;
  logic [MAXLEN:0]   acc_wide;
  logic [MAXLEN-1:0] acc_next;
  logic [3:0]        n_next;
  logic              hit;
  logic [3:0]        hit_idx;

  // Table storage; clear takes priority over a write in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < 16; i++) begin
        len_q[i]  <= '0;
        code_q[i] <= '0;
      end
    end else if (tbl_clr) begin
      for (int unsigned i = 0; i < 16; i++) begin
        len_q[i] <= '0;
      end
    end else if (tbl_we) begin
      len_q[tbl_addr]  <= tbl_len;
      code_q[tbl_addr] <= tbl_code;
    end
  end

  assign bit_ready = !sym_valid_q || sym_ready;
  assign accept    = bit_valid && bit_ready;

  // Widened shift keeps the expression legal for MAXLEN == 1.
  assign acc_wide = {acc_q, bit_in};
  assign acc_next = acc_wide[MAXLEN-1:0];
  assign n_next   = n_q + 4'd1;

  // Match search; the first hit in ascending index order is kept, so the
  // lowest index wins on an ill-formed table.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!hit && (len_q[i] != 4'd0) && (len_q[i] == n_next) &&
          (code_q[i] == acc_next)) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    n_d         = n_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = sym_valid_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    if (sym_valid_q && sym_ready) begin
      sym_valid_d = 1'b0;
      cnt_d       = cnt_q + CNTW'(1);
    end

    // A match in the handoff cycle re-raises valid, so one bit per cycle
    // streams without bubbles.
    if (accept) begin
      if (hit) begin
        sym_out_d   = hit_idx;
        sym_valid_d = 1'b1;
        acc_d       = '0;
        n_d         = '0;
      end else if (n_next == 4'(MAXLEN)) begin
        err_d = 1'b1;
        acc_d = '0;
        n_d   = '0;
      end else begin
        acc_d = acc_next;
        n_d   = n_next;
      end
    end

    if (tbl_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q       <= '0;
      n_q         <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      n_q         <= n_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sym_out   = sym_out_q;
  assign sym_valid = sym_valid_q;
  assign err       = err_q;
  assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_huff_bit_decoder.sv
module tb_huff_bit_decoder;

  localparam int unsigned MAXLEN = 15;
  localparam int unsigned CNTW   = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              tbl_we = 1'b0;
  logic [3:0]        tbl_addr = '0;
  logic [3:0]        tbl_len = '0;
  logic [MAXLEN-1:0] tbl_code = '0;
  logic              tbl_clr = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_ready;
  logic [3:0]        sym_out;
  logic              sym_valid;
  logic              sym_ready = 1'b1;
  logic              err;
  logic [CNTW-1:0]   sym_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  huff_bit_decoder #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_len(tbl_len),
    .tbl_code(tbl_code), .tbl_clr(tbl_clr),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .err(err), .sym_cnt(sym_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handoff occurs at the next rising edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", int'(sym_out), -1);
        end else begin
          check("sym_out", int'(sym_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tbl_op(input logic we, input logic clr, input logic [3:0] a,
                        input logic [3:0] l, input logic [MAXLEN-1:0] c);
    tbl_we = we; tbl_clr = clr; tbl_addr = a; tbl_len = l; tbl_code = c;
    cycle(1);
    tbl_we = 1'b0; tbl_clr = 1'b0;
  endtask

  // Drives one bit until accepted; returns #1 after the accepting edge.
  task automatic send_bit(input logic b);
    logic acc;
    acc = 1'b0;
    bit_in = b;
    bit_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge CLK);
      acc = bit_ready;
      @(posedge CLK);
      #1;
    end
    bit_valid = 1'b0;
    if (!acc) check("bit_accept_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_out", int'(sym_out), 0);
    check("rst_err", int'(err), 0);
    check("rst_cnt", int'(sym_cnt), 0);
    check("rst_bit_ready", int'(bit_ready), 1);
    cycle(2);
    RST = 1'b0;
    cycle(1);

    // Basic decode: 3="0", 5="10", 9="11"
    tbl_op(1, 0, 4'd3, 4'd1, 15'd0);
    tbl_op(1, 0, 4'd5, 4'd2, 15'd2);
    tbl_op(1, 0, 4'd9, 4'd2, 15'd3);
    exp_q.push_back(4'd3);
    send_bit(0);
    check("basic_lat3_valid", int'(sym_valid), 1);
    check("basic_lat3_out", int'(sym_out), 3);
    send_bit(1);
    check("basic_mid_valid", int'(sym_valid), 0);
    exp_q.push_back(4'd5);
    send_bit(0);
    check("basic_lat5_out", int'(sym_out), 5);
    send_bit(1);
    exp_q.push_back(4'd9);
    send_bit(1);
    check("basic_lat9_valid", int'(sym_valid), 1);
    check("basic_lat9_out", int'(sym_out), 9);
    cycle(3);
    check("basic_cnt", int'(sym_cnt), 3);
    check("basic_err", int'(err), 0);

    // Backpressure
    sym_ready = 1'b0;
    exp_q.push_back(4'd3);
    send_bit(0);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_bit_ready", int'(bit_ready), 0);
      check("bp_hold_valid", int'(sym_valid), 1);
      check("bp_hold_out", int'(sym_out), 3);
    end
    @(posedge CLK);
    #1;
    check("bp_cnt_held", int'(sym_cnt), 3);
    sym_ready = 1'b1;
    send_bit(1);
    exp_q.push_back(4'd5);
    send_bit(0);
    send_bit(1);
    exp_q.push_back(4'd9);
    send_bit(1);
    cycle(3);
    check("bp_cnt", int'(sym_cnt), 6);

    // Error path: only 1="0"; fifteen ones
    tbl_op(0, 1, 4'd0, 4'd0, 15'd0);
    tbl_op(1, 0, 4'd1, 4'd1, 15'd0);
    for (int i = 0; i < 14; i++) send_bit(1);
    check("err_before", int'(err), 0);
    send_bit(1);
    check("err_after15", int'(err), 1);
    check("err_no_sym", int'(sym_valid), 0);
    exp_q.push_back(4'd1);
    send_bit(0);
    check("err_resume_out", int'(sym_out), 1);
    cycle(3);
    check("err_cnt", int'(sym_cnt), 7);

    // Clear + write same cycle: clear wins
    tbl_op(1, 1, 4'd2, 4'd1, 15'd1);
    check("clr_err_cleared", int'(err), 0);
    for (int i = 0; i < 14; i++) send_bit(1);
    check("clr_err_before", int'(err), 0);
    send_bit(1);
    check("clr_empty_err", int'(err), 1);
    tbl_op(1, 0, 4'd2, 4'd1, 15'd1);
    exp_q.push_back(4'd2);
    send_bit(1);
    check("clr_rewrite_out", int'(sym_out), 2);
    cycle(3);
    check("clr_cnt", int'(sym_cnt), 8);
    check("clr_err_sticky", int'(err), 1);

    // Async reset mid-code
    tbl_op(1, 0, 4'd2, 4'd0, 15'd0);
    tbl_op(1, 0, 4'd5, 4'd2, 15'd2);
    send_bit(1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_sym_out", int'(sym_out), 0);
    check("arst_err", int'(err), 0);
    check("arst_cnt", int'(sym_cnt), 0);
    check("arst_valid", int'(sym_valid), 0);
    cycle(2);
    RST = 1'b0;
    cycle(1);
    tbl_op(1, 0, 4'd5, 4'd2, 15'd2);
    send_bit(1);
    check("arst_no_partial", int'(sym_valid), 0);
    exp_q.push_back(4'd5);
    send_bit(0);
    check("arst_out5", int'(sym_out), 5);
    cycle(3);
    check("arst_cnt1", int'(sym_cnt), 1);

    // Counter wrap with back-to-back symbols
    RST = 1'b1;
    cycle(1);
    RST = 1'b0;
    cycle(1);
    tbl_op(1, 0, 4'd3, 4'd1, 15'd0);
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(4'd3);
      send_bit(0);
      check("wrap_valid_cont", int'(sym_valid), 1);
    end
    cycle(3);
    check("wrap_cnt", int'(sym_cnt), 1);
    check("wrap_drained", int'(sym_valid), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
